rx_command_dispatcher: RTL and testbench
========================================

// Module: rx_command_dispatcher
// PURPOSE
//  Drains the 72-bit command words ({command[7:0], data[63:0]}) buffered by the async serial
//  receiver FIFO and routes each word to one of NUM_DEST consumers, selected by the top DEST_W
//  bits of the command byte. Each word is held on its consumer until that consumer acks it.
//  Words for disabled consumers are dropped. Consumers that never ack are timed out.
//  Drop and timeout events are counted for host diagnostics.
// PARAMETERS
//  DEST_W    2     destination select width; index = rx_command[7 -: DEST_W]
//  NUM_DEST  4     number of consumers, must equal 2**DEST_W
//  TIMEOUT   4095  max DELIVER cycles awaiting ack; 0 = wait forever
//  CNT_W     16    width of the diagnostic counters
// PORTS
//  clk            in   1         system clock, all logic on posedge
//  rst_n          in   1         asynchronous active-low reset
//  rx_valid       in   1         receiver FIFO not empty
//  rx_command     in   8         FIFO dout command byte, valid 1 cycle after rx_rd_en (std FIFO)
//  rx_data        in   64        FIFO dout data, same timing as rx_command
//  rx_rd_en       out  1         FIFO pop strobe, registered, 1-cycle pulse
//  dest_enable    in   NUM_DEST  per-consumer enable, sampled in CAPTURE
//  dst_valid      out  NUM_DEST  one-hot word-present flag, registered
//  dst_command    out  8         latched command byte, shared by all consumers
//  dst_data       out  64        latched data word, shared by all consumers
//  dst_ack        in   NUM_DEST  consumer accept; only the bit matching the active dst_valid counts
//  busy           out  1         high in any state other than IDLE
//  drop_count     out  CNT_W     words dropped because the destination was disabled, saturating
//  timeout_count  out  CNT_W     deliveries aborted by timeout, saturating
//  clear_counts   in   1         synchronous clear of both counters
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0.
//   Captured registers and the timer clear to 0. A word already popped is lost (documented).
//  FSM states: IDLE, POP, CAPTURE, DELIVER.
//   IDLE:    rx_valid=1 -> rx_rd_en<=1, go POP.
//   POP:     rx_rd_en<=0; FIFO dout updates this edge; go CAPTURE.
//   CAPTURE: latch rx_command/rx_data into dst_command/dst_data; idx = rx_command[7 -: DEST_W].
//            dest_enable[idx]=1 -> dst_valid<=(1<<idx), timer<=0, go DELIVER.
//            else -> drop_count++ (saturating), go IDLE.
//   DELIVER: dst_valid held constant.
//            dst_ack[idx]=1 at a posedge -> dst_valid<=0, go IDLE.
//            else if TIMEOUT!=0 and timer==TIMEOUT-1 -> dst_valid<=0, timeout_count++, go IDLE.
//            else timer++.
//  Latency: rx_valid high at edge N -> rx_rd_en high N+1..N+2 -> dst_valid high after edge N+3.
//   Throughput with immediate ack: one word per 4 cycles.
//  dst_command/dst_data change only in CAPTURE; they hold their last value while idle.
//  dst_valid is never multi-hot. Acks on non-selected bits and acks outside DELIVER are ignored.
//  Ack and timeout in the same cycle: ack wins, no count.
//  dest_enable deasserted during DELIVER does not abort the transfer.
//  Counters saturate at all-ones and do not wrap.
//  clear_counts has priority over a same-cycle increment; the result is 0.
//  rx_valid is ignored outside IDLE. No pop occurs while a word is outstanding.
//  rx_rd_en is never asserted while rx_valid=0.
//  TIMEOUT=1: abort after 1 DELIVER cycle without ack.
//  Timer width is clog2(TIMEOUT+1).
// TESTING
//  1. rx_valid with word 0x40_0123456789ABCDEF, all enabled, dst_ack[1] held 1
//     -> rx_rd_en one pulse; dst_valid=4'b0010 for 1 cycle, 3 cycles after rx_valid;
//        dst_data=0x0123456789ABCDEF.
//  2. Command 0xC5 with dest_enable=4'b0111
//     -> no dst_valid; drop_count 0->1; FSM back in IDLE after 3 cycles.
//  3. TIMEOUT=8, command 0x00, no ack
//     -> dst_valid[0] high exactly 8 cycles; timeout_count=1.
//     Repeat with ack in the 8th cycle -> delivered, timeout_count unchanged.
//  4. Three queued words (dests 3,0,2), acks delayed 5 cycles
//     -> delivered in FIFO order, one-hot each time, exactly 3 rx_rd_en pulses;
//        dst_ack on a wrong bit ignored.
//  5. drop_count preloaded to 0xFFFE, 3 drops -> stops at 0xFFFF.
//     clear_counts coincident with a drop -> 0.
//  6. rst_n low mid-DELIVER (dst_valid=4'b0100)
//     -> all outputs 0 immediately; after release, the next queued word is popped normally.

Source files
------------

// File: rtl/rx_command_dispatcher.sv
// Pops 72-bit command words from the serial receiver FIFO and holds each on one of NUM_DEST
// consumers (selected by the top command bits) until acked, dropped or timed out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the receiver FIFO to become non-empty
// S_POP     | pop strobe issued; FIFO dout updates on this edge
// S_CAPTURE | latch word, check destination enable, drop or deliver
// S_DELIVER | word held on one consumer until ack or timeout
module rx_command_dispatcher #(
    parameter int DEST_W   = 2,
    parameter int NUM_DEST = 4,
    parameter int TIMEOUT  = 4095,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_command,
    input  logic [63:0]         rx_data,
    output logic                rx_rd_en,
    input  logic [NUM_DEST-1:0] dest_enable,
    output logic [NUM_DEST-1:0] dst_valid,
    output logic [7:0]          dst_command,
    output logic [63:0]         dst_data,
    input  logic [NUM_DEST-1:0] dst_ack,
    output logic                busy,
    output logic [CNT_W-1:0]    drop_count,
    output logic [CNT_W-1:0]    timeout_count,
    input  logic                clear_counts
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_POP     = 2'd1,
        S_CAPTURE = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                rd_en_q, rd_en_d;
    logic [NUM_DEST-1:0] valid_q, valid_d;
    logic [7:0]          cmd_q, cmd_d;
    logic [63:0]         data_q, data_d;
    logic [DEST_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic                drop_inc, tmo_inc;
    logic [DEST_W-1:0]   rx_idx;

    assign rx_idx = rx_command[7 -: DEST_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
            valid_q <= '0;
            cmd_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            drop_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            drop_q  <= drop_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rd_en_d  = 1'b0;
        valid_d  = valid_q;
        cmd_d    = cmd_q;
        data_d   = data_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        drop_inc = 1'b0;
        tmo_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    rd_en_d = 1'b1;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                cmd_d  = rx_command;
                data_d = rx_data;
                idx_d  = rx_idx;
                if (dest_enable[rx_idx]) begin
                    valid_d = NUM_DEST'(1) << rx_idx;
                    timer_d = '0;
                    state_d = S_DELIVER;
                end else begin
                    drop_inc = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_DELIVER: begin
                // ack is checked first so a same-cycle ack beats the timeout
                if (dst_ack[idx_q]) begin
                    valid_d = '0;
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
                    valid_d = '0;
                    tmo_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                valid_d = '0;
                state_d = S_IDLE;
            end
        endcase

        if (clear_counts) begin
            drop_d = '0;
            tmo_d  = '0;
        end else begin
            drop_d = (drop_inc && (drop_q != '1)) ? drop_q + CNT_W'(1) : drop_q;
            tmo_d  = (tmo_inc && (tmo_q != '1)) ? tmo_q + CNT_W'(1) : tmo_q;
        end
    end

    assign rx_rd_en      = rd_en_q;
    assign dst_valid     = valid_q;
    assign dst_command   = cmd_q;
    assign dst_data      = data_q;
    assign busy          = (state_q != S_IDLE);
    assign drop_count    = drop_q;
    assign timeout_count = tmo_q;

endmodule

// File: tb/tb_rx_command_dispatcher.sv
// Directed bench for rx_command_dispatcher: a FIFO model feeds the main instance
// (TIMEOUT=8); a second instance (TIMEOUT=1, 2-bit counters) covers saturation and short timeout.
module tb_rx_command_dispatcher;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rx_valid;
    logic [7:0]  rx_command = '0;
    logic [63:0] rx_data = '0;
    logic        rx_rd_en;
    logic [3:0]  dest_enable = '0;
    logic [3:0]  dst_valid;
    logic [7:0]  dst_command;
    logic [63:0] dst_data;
    logic [3:0]  dst_ack = '0;
    logic        busy;
    logic [15:0] drop_count;
    logic [15:0] timeout_count;
    logic        clear_counts = 1'b0;

    logic        s_rx_valid = 1'b0;
    logic [7:0]  s_rx_command = '0;
    logic [63:0] s_rx_data = 64'h0000_0000_5A5A_A5A5;
    logic        s_rx_rd_en;
    logic [3:0]  s_dest_enable = '0;
    logic [3:0]  s_dst_valid;
    logic [7:0]  s_dst_command;
    logic [63:0] s_dst_data;
    logic [3:0]  s_dst_ack = '0;
    logic        s_busy;
    logic [1:0]  s_drop_count;
    logic [1:0]  s_timeout_count;
    logic        s_clear = 1'b0;

    rx_command_dispatcher #(.DEST_W(2), .NUM_DEST(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_command(rx_command),
        .rx_data(rx_data), .rx_rd_en(rx_rd_en), .dest_enable(dest_enable),
        .dst_valid(dst_valid), .dst_command(dst_command), .dst_data(dst_data),
        .dst_ack(dst_ack), .busy(busy), .drop_count(drop_count),
        .timeout_count(timeout_count), .clear_counts(clear_counts)
    );

    rx_command_dispatcher #(.DEST_W(2), .NUM_DEST(4), .TIMEOUT(1), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .rx_valid(s_rx_valid), .rx_command(s_rx_command),
        .rx_data(s_rx_data), .rx_rd_en(s_rx_rd_en), .dest_enable(s_dest_enable),
        .dst_valid(s_dst_valid), .dst_command(s_dst_command), .dst_data(s_dst_data),
        .dst_ack(s_dst_ack), .busy(s_busy), .drop_count(s_drop_count),
        .timeout_count(s_timeout_count), .clear_counts(s_clear)
    );

    // standard-mode FIFO model: dout updates on the edge that samples rd_en
    logic [71:0] fifo_mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit bad_pop = 1'b0;

    assign rx_valid = (wr_ptr != rd_ptr);

    always @(posedge clk) begin
        if (rx_rd_en) begin
            if (!rx_valid) begin
                bad_pop <= 1'b1;
            end else begin
                {rx_command, rx_data} <= fifo_mem[rd_ptr[3:0]];
                rd_ptr <= rd_ptr + 1;
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] cmd, input logic [63:0] data);
        fifo_mem[wr_ptr[3:0]] = {cmd, data};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while ((dst_valid == 4'b0000) && (n < 16)) begin
            step();
            n++;
        end
        check(tag, 72'(dst_valid != 4'b0000), 72'(1));
    endtask

    task automatic s_drop(input bit with_clear);
        s_rx_valid = 1'b1;
        step();
        step();
        s_rx_valid = 1'b0;
        s_clear = with_clear;
        step();
        s_clear = 1'b0;
    endtask

    logic [7:0]  t4_cmd [0:2];
    logic [3:0]  t4_hot [0:2];
    logic [63:0] t4_dat [0:2];

    initial begin
        int hi;
        t4_cmd = '{8'hC1, 8'h02, 8'h83};
        t4_hot = '{4'b1000, 4'b0001, 4'b0100};
        t4_dat = '{64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0003};

        // reset state
        repeat (2) step();
        check("rst_rd_en", 72'(rx_rd_en), 72'(0));
        check("rst_dst_valid", 72'(dst_valid), 72'(0));
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_drop", 72'(drop_count), 72'(0));
        check("rst_timeout", 72'(timeout_count), 72'(0));
        check("rst_data", 72'(dst_data), 72'(0));
        rst_n = 1'b1;
        step();

        // 1: basic delivery with ack already held high
        dest_enable = 4'hF;
        dst_ack = 4'b0010;
        push(8'h40, 64'h0123_4567_89AB_CDEF);
        step();
        check("t1_c1_rd_en", 72'(rx_rd_en), 72'(1));
        check("t1_c1_valid", 72'(dst_valid), 72'(0));
        check("t1_c1_busy", 72'(busy), 72'(1));
        step();
        check("t1_c2_rd_en", 72'(rx_rd_en), 72'(0));
        check("t1_c2_valid", 72'(dst_valid), 72'(0));
        step();
        check("t1_c3_valid", 72'(dst_valid), 72'(4'b0010));
        check("t1_c3_data", 72'(dst_data), 72'(64'h0123_4567_89AB_CDEF));
        check("t1_c3_cmd", 72'(dst_command), 72'(8'h40));
        step();
        check("t1_c4_valid", 72'(dst_valid), 72'(0));
        check("t1_c4_busy", 72'(busy), 72'(0));
        check("t1_pops", 72'(rd_ptr), 72'(1));
        dst_ack = 4'b0000;

        // 2: disabled destination is dropped
        dest_enable = 4'b0111;
        push(8'hC5, 64'hDEAD_BEEF_0000_0001);
        step();
        check("t2_c1_busy", 72'(busy), 72'(1));
        step();
        check("t2_c2_valid", 72'(dst_valid), 72'(0));
        step();
        check("t2_c3_busy", 72'(busy), 72'(0));
        check("t2_c3_valid", 72'(dst_valid), 72'(0));
        check("t2_drop", 72'(drop_count), 72'(1));
        check("t2_cmd", 72'(dst_command), 72'(8'hC5));
        dest_enable = 4'hF;

        // 3a: no ack, times out after exactly 8 cycles
        push(8'h00, 64'h1111);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dst_valid == 4'b0001) hi++;
        end
        check("t3_high_cycles", 72'(hi), 72'(8));
        check("t3_timeout", 72'(timeout_count), 72'(1));
        check("t3_busy", 72'(busy), 72'(0));

        // 3b: ack in the 8th cycle beats the timeout
        push(8'h00, 64'h2222);
        repeat (3) step();
        check("t3b_first", 72'(dst_valid), 72'(4'b0001));
        repeat (7) step();
        check("t3b_8th", 72'(dst_valid), 72'(4'b0001));
        dst_ack = 4'b0001;
        step();
        dst_ack = 4'b0000;
        check("t3b_done", 72'(dst_valid), 72'(0));
        check("t3b_timeout", 72'(timeout_count), 72'(1));

        // 4: three queued words, wrong-bit acks, then delayed correct ack
        for (int k = 0; k < 3; k++) push(t4_cmd[k], t4_dat[k]);
        for (int k = 0; k < 3; k++) begin
            wait_valid("t4_wait");
            check("t4_onehot", 72'(dst_valid), 72'(t4_hot[k]));
            check("t4_data", 72'(dst_data), 72'(t4_dat[k]));
            dst_ack = ~t4_hot[k];
            repeat (4) step();
            check("t4_wrong_ack", 72'(dst_valid), 72'(t4_hot[k]));
            dst_ack = t4_hot[k];
            step();
            dst_ack = 4'b0000;
            check("t4_acked", 72'(dst_valid), 72'(0));
        end
        check("t4_pops", 72'(rd_ptr), 72'(7));
        check("t4_timeout", 72'(timeout_count), 72'(1));

        clear_counts = 1'b1;
        step();
        clear_counts = 1'b0;
        check("clr_drop", 72'(drop_count), 72'(0));
        check("clr_timeout", 72'(timeout_count), 72'(0));

        // 5: saturation and clear-vs-increment on the 2-bit counter instance
        s_rx_command = 8'hC5;
        s_drop(1'b0);
        s_drop(1'b0);
        check("t5_pre", 72'(s_drop_count), 72'(2));
        s_drop(1'b0);
        check("t5_sat1", 72'(s_drop_count), 72'(3));
        s_drop(1'b0);
        check("t5_sat2", 72'(s_drop_count), 72'(3));
        s_drop(1'b1);
        check("t5_clear_wins", 72'(s_drop_count), 72'(0));
        s_drop(1'b0);
        check("t5_after_clr", 72'(s_drop_count), 72'(1));

        // TIMEOUT=1: one DELIVER cycle then abort
        s_dest_enable = 4'hF;
        s_rx_command = 8'h40;
        s_rx_valid = 1'b1;
        step();
        step();
        s_rx_valid = 1'b0;
        step();
        check("t5_to1_valid", 72'(s_dst_valid), 72'(4'b0010));
        check("t5_to1_data", 72'(s_dst_data), 72'(64'h0000_0000_5A5A_A5A5));
        step();
        check("t5_to1_off", 72'(s_dst_valid), 72'(0));
        check("t5_to1_count", 72'(s_timeout_count), 72'(1));

        // 6: reset mid-delivery, next word still popped afterwards
        push(8'h80, 64'h6666);
        push(8'h40, 64'h7777);
        wait_valid("t6_wait");
        check("t6_valid", 72'(dst_valid), 72'(4'b0100));
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 72'(dst_valid), 72'(0));
        check("t6_rst_busy", 72'(busy), 72'(0));
        check("t6_rst_rd_en", 72'(rx_rd_en), 72'(0));
        check("t6_rst_data", 72'(dst_data), 72'(0));
        check("t6_rst_cmd", 72'(dst_command), 72'(0));
        check("t6_rst_small_to", 72'(s_timeout_count), 72'(0));
        step();
        rst_n = 1'b1;
        wait_valid("t6_wait2");
        check("t6_next_valid", 72'(dst_valid), 72'(4'b0010));
        check("t6_next_data", 72'(dst_data), 72'(64'h7777));
        dst_ack = 4'b0010;
        step();
        dst_ack = 4'b0000;
        check("t6_done", 72'(busy), 72'(0));
        check("t6_pops", 72'(rd_ptr), 72'(9));
        check("no_pop_when_empty", 72'(bad_pop), 72'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
